// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I ID/EX pipeline register with load-use hazard detection and event counters
//
// Purpose:
//   Registers the decode-stage control word and operands for the execute stage.
//   Detects load-use hazards against the instruction currently in EX, stalls
//   fetch/decode and injects a bubble. A taken branch/jump (PCSrcE) flushes
//   decode and also injects a bubble; the redirect wins over the stall.
//   Two saturating counters record stall and flush events.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ValidD, *D               decode-stage control and operands
//   PCSrcE                   taken branch/jump resolved in EX this cycle
//   ValidE, *E               registered copies presented to EX
//   StallF, StallD, FlushD   combinational hazard controls for IF and IF/ID
//   StallCount, FlushCount   saturating event counters
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       ALUControlD,
  input  logic [2:0]       Funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             PCSrcE,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [3:0]       ALUControlE,
  output logic [2:0]       Funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic lw_stall;
  logic bubble;
  logic stall_evt;

  // Source registers are compared without opcode qualification; a spurious
  // match on U/J-type costs one extra stall cycle and is harmless.
  always_comb begin
    lw_stall = ValidD & ValidE & RegWriteE & (ResultSrcE == 2'b01) &
               (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  end

  // A redirect discards the decode instruction anyway, so it overrides the stall.
  assign stall_evt = lw_stall & ~PCSrcE;
  assign StallF    = stall_evt;
  assign StallD    = stall_evt;
  assign FlushD    = PCSrcE;
  assign bubble    = PCSrcE | lw_stall;

  // The stage never holds: a stall is always seen by EX as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      Funct3E     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else if (bubble) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      Funct3E     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      ValidE      <= ValidD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      Funct3E     <= Funct3D;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  // Counters saturate at all-ones so long runs never alias back to small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_evt && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + CNT_W'(1);
      if (PCSrcE && (FlushCount != {CNT_W{1'b1}}))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]       ResultSrcD;
  logic [3:0]       ALUControlD;
  logic [2:0]       Funct3D;
  logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             PCSrcE;
  logic             ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic [3:0]       ALUControlE;
  logic [2:0]       Funct3E;
  logic [XLEN-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             StallF, StallD, FlushD;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int total;
  int bad;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    ValidD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 0; ALUControlD = 0; Funct3D = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic drive_instr(input logic rw, input logic [1:0] rsrc,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd);
    clear_d();
    ValidD = 1; RegWriteD = rw; ResultSrcD = rsrc;
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
    ALUControlD = 4'b0110; RD1D = 32'hA5A5_0001; PCD = 32'h100;
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear_d();
    PCSrcE = 0;
    rst_n = 0;
    #12;
    check("reset_validE", ValidE, 0);
    check("reset_stallcnt", StallCount, 0);
    check("reset_flushcnt", FlushCount, 0);
    check("reset_stallF", StallF, 0);
    check("reset_flushD", FlushD, 0);
    @(negedge clk);
    rst_n = 1;

    // pass-through
    clear_d();
    ValidD = 1; ALUControlD = 4'b0010; RD1D = 32'h11; RdD = 5; ImmExtD = 32'h44;
    step();
    check("pt_aluctl", ALUControlE, 4'b0010);
    check("pt_rd1", RD1E, 32'h11);
    check("pt_rd", RdE, 5);
    check("pt_imm", ImmExtE, 32'h44);
    check("pt_valid", ValidE, 1);

    // asynchronous reset mid-cycle, no clock edge in between
    #3;
    rst_n = 0;
    #1;
    check("arst_valid", ValidE, 0);
    check("arst_rd1", RD1E, 0);
    check("arst_rd", RdE, 0);
    check("arst_aluctl", ALUControlE, 0);
    @(negedge clk);
    rst_n = 1;

    // load-use: lw x5, then consumer of x5
    drive_instr(1, 2'b01, 0, 0, 5);
    step();
    check("lu_loadE_rs", ResultSrcE, 2'b01);
    drive_instr(1, 2'b00, 5, 0, 6);
    #1;
    check("lu_stallF", StallF, 1);
    check("lu_stallD", StallD, 1);
    check("lu_flushD", FlushD, 0);
    step();
    check("lu_bubble_valid", ValidE, 0);
    check("lu_bubble_rw", RegWriteE, 0);
    check("lu_bubble_rd1", RD1E, 0);
    check("lu_stallcnt", StallCount, 1);
    check("lu_stall_drop", StallF, 0);
    step();
    check("lu_dep_valid", ValidE, 1);
    check("lu_dep_rd", RdE, 6);

    // load to x0 with Rs1D = 0: no stall
    drive_instr(1, 2'b01, 0, 0, 0);
    step();
    drive_instr(1, 2'b00, 0, 0, 9);
    #1;
    check("x0_stallF", StallF, 0);
    step();
    check("x0_nobubble", ValidE, 1);
    check("x0_rd", RdE, 9);

    // ALU producer x7, consumer on Rs2: no stall
    drive_instr(1, 2'b00, 0, 0, 7);
    step();
    drive_instr(1, 2'b00, 0, 7, 8);
    #1;
    check("alu_stallF", StallF, 0);
    step();
    check("alu_nobubble", ValidE, 1);
    check("alu_rd", RdE, 8);
    check("alu_stallcnt", StallCount, 1);

    // branch flush
    drive_instr(1, 2'b00, 1, 2, 3);
    ALUSrcD = 1; BranchD = 1;
    PCSrcE = 1;
    #1;
    check("br_flushD", FlushD, 1);
    check("br_stallF", StallF, 0);
    step();
    PCSrcE = 0;
    check("br_valid", ValidE, 0);
    check("br_rw", RegWriteE, 0);
    check("br_alusrc", ALUSrcE, 0);
    check("br_branch", BranchE, 0);
    check("br_aluctl", ALUControlE, 0);
    check("br_flushcnt", FlushCount, 1);

    // simultaneous load-use and redirect
    drive_instr(1, 2'b01, 0, 0, 5);
    step();
    drive_instr(1, 2'b00, 0, 5, 4);
    PCSrcE = 1;
    #1;
    check("both_stallF", StallF, 0);
    check("both_stallD", StallD, 0);
    check("both_flushD", FlushD, 1);
    step();
    PCSrcE = 0;
    check("both_valid", ValidE, 0);
    check("both_flushcnt", FlushCount, 2);
    check("both_stallcnt", StallCount, 1);
    step();
    check("both_next_valid", ValidE, 1);

    // saturation: 20 redirects from FlushCount = 2
    PCSrcE = 1;
    for (int i = 0; i < 13; i++) step();
    check("sat_reach", FlushCount, 4'hF);
    for (int i = 0; i < 7; i++) step();
    check("sat_hold", FlushCount, 4'hF);
    PCSrcE = 0;
    step();
    check("sat_after", FlushCount, 4'hF);
    check("sat_stallcnt", StallCount, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the five-stage RV32I core. Captures the decoder control word (ALUControl, ImmSrc-resolved immediate, ResultSrc, MemWrite, ALUSrc, RegWrite, Branch, Jump) and decode-stage operands, then presents them to the execute stage one cycle later. Also contains the load-use hazard detector, which stalls fetch/decode and inserts bubbles, and it converts a taken branch or jump from EX into a decode flush plus bubble. Two saturating event counters provide performance visibility.

## Interface
- XLEN, 32, datapath width.
- CNT_W, 16, width of each event counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ValidD  in  1  decode slot holds a real instruction.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoder control.
- ResultSrcD  in  2  result select; 2'b01 = load.
- ALUControlD  in  4  ALU operation.
- Funct3D  in  3  memory size / branch condition.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  decode operands.
- Rs1D, Rs2D, RdD  in  5 each  register indices.
- PCSrcE  in  1  taken branch/jump resolved in EX this cycle.
- All `*D` fields  out  same widths, renamed `*E`  registered copies.
- ValidE  out  1  execute slot holds a real instruction.
- StallF, StallD  out  1  hold PC and IF/ID register.
- FlushD  out  1  clear IF/ID register.
- StallCount, FlushCount  out  CNT_W  saturating event counters.

## Operation
- Load-use detect, combinational: lwStall = ValidD & ValidE & RegWriteE & (ResultSrcE == 2'b01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- No opcode qualification of Rs1D/Rs2D. U/J-type spurious matches cost one extra stall cycle, and this is accepted.
- StallF = StallD = lwStall & ~PCSrcE. A taken redirect overrides the stall.
- FlushD = PCSrcE.
- Register update on each rising clk edge:
  - bubble = PCSrcE | lwStall.
  - When bubble is asserted, every `*E` output, including the data fields, loads 0, and ValidE loads 0.
  - Otherwise every `*E` field loads its `*D` input, and ValidE loads ValidD.
- Priority: PCSrcE over lwStall. When both are asserted in the same cycle, the block flushes and does not stall. Only FlushCount increments.
- Counters:
  - StallCount increments when lwStall & ~PCSrcE.
  - FlushCount increments when PCSrcE.
  - Both saturate at all-ones and never wrap.
- The block never holds its own register contents. A stall always presents as a bubble in EX.

## Timing
- Latency: `*D` inputs sampled at edge N appear on `*E` outputs after edge N, for use in cycle N+1.
- StallF, StallD and FlushD are combinational, in the same cycle as the condition. Upstream registers act on them at the next edge.
- A load followed by a dependent instruction gives exactly one stall cycle and one bubble. On the following edge the dependent instruction enters EX, since the bubble has ValidE = 0.
- Reset, asynchronous: all `*E` outputs = 0, ValidE = 0, and StallCount = FlushCount = 0.
  - StallF, StallD and FlushD then evaluate to 0 unless PCSrcE is driven.
- Reset deassertion is synchronised externally. The first capture occurs at the first rising edge with rst_n high.
- Reset asserted mid-stall clears state immediately, and the stall drops in the same cycle.

## Test plan
- Reset then pass-through:
  - Stimulus: assert rst_n = 0 mid-cycle.
  - Required: all outputs 0 asynchronously.
  - Stimulus: release reset, then drive ValidD = 1, ALUControlD = 4'b0010, RD1D = 0x11, RdD = 5.
  - Required: after one edge, ALUControlE = 4'b0010, RD1E = 0x11, RdE = 5, ValidE = 1.
- Load-use stall:
  - Stimulus: lw x5 captured (ResultSrcE = 01, RegWriteE = 1, RdE = 5), next decode has Rs1D = 5.
  - Required: StallF = StallD = 1 that cycle, then bubble (ValidE = 0, RegWriteE = 0), then the dependent instruction in EX.
  - Required: StallCount = 1.
- No stall on x0 or non-load:
  - Stimulus: RdE = 0 load with Rs1D = 0; separately, an ALU op (ResultSrcE = 00) with RdE = Rs2D = 7.
  - Required: lwStall = 0 in both cases, and no bubble.
- Branch flush:
  - Stimulus: PCSrcE = 1 for one cycle.
  - Required: FlushD = 1 that cycle, next ValidE = 0 with all control 0, FlushCount = 1.
- Simultaneous stall and flush:
  - Stimulus: load-use condition and PCSrcE = 1 in the same cycle.
  - Required: StallF = 0, FlushD = 1, a single bubble, FlushCount +1, StallCount unchanged.
- Counter saturation:
  - Stimulus: CNT_W = 4, drive 20 consecutive PCSrcE cycles.
  - Required: FlushCount stops at 4'hF.
